// File: rtl/freq_divider_param.sv
// freq_divider_param: programmable clock divider with glitch-free divisor reload at period boundaries.
module freq_divider_param #(
  parameter int W = 8,
  parameter int RESET_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] ndiv,
  input  logic         load,
  output logic         div_out,
  output logic         div_pulse,
  output logic         load_ack,
  output logic [W-1:0] phase
);
  logic [W-1:0] cnt, n, pending, cnt_nx, n_nx, pending_nx, n_new;
  logic [W:0]   h;
  logic         started, pend, pend_nx, boundary, wrap, out_nx, pulse_nx, ack_nx;
  assign phase = cnt;
  always_comb begin
    boundary   = !started || n == '0 || cnt == n - 1'b1;
    wrap       = en && boundary;
    n_new      = load ? ndiv : pend ? pending : n;
    n_nx       = wrap ? n_new : n;
    cnt_nx     = en ? (boundary ? '0 : cnt + 1'b1) : cnt;
    // H is formed one bit wider so N = 2^W-1 rounds up without wrapping
    h          = ({1'b0, n_nx} + 1'b1) >> 1;
    out_nx     = en ? (n_nx != '0 && {1'b0, cnt_nx} < h) : div_out;
    pulse_nx   = en && n_nx != '0 && cnt_nx == '0;
    ack_nx     = wrap && (load || pend);
    pend_nx    = wrap ? 1'b0 : (load || pend);
    pending_nx = (load && !wrap) ? ndiv : pending;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      n         <= RESET_DIV[W-1:0];
      pending   <= '0;
      pend      <= 1'b0;
      started   <= 1'b0;
      div_out   <= 1'b0;
      div_pulse <= 1'b0;
      load_ack  <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      n         <= n_nx;
      pending   <= pending_nx;
      pend      <= pend_nx;
      started   <= started || en;
      div_out   <= out_nx;
      div_pulse <= pulse_nx;
      load_ack  <= ack_nx;
    end
  end
endmodule

// File: tb/tb_freq_divider_param.sv
// tb_freq_divider_param: directed and random stimulus against a cycle-level divider model, scoreboard-checked.
module tb_freq_divider_param;
  logic       clk = 1'b0, reset = 1'b1, en = 1'b0, load = 1'b0;
  logic [7:0] ndiv = '0;
  logic       div_out, div_pulse, load_ack;
  logic [7:0] phase;
  int checks = 0, errors = 0;

  typedef struct { int ph; int o; int p; int a; } exp_t;
  exp_t q[$];

  int m_n, m_k, m_started, m_pend, m_pending, m_out, m_pulse, m_ack;

  freq_divider_param #(.W(8), .RESET_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .ndiv(ndiv), .load(load),
    .div_out(div_out), .div_pulse(div_pulse), .load_ack(load_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 4; m_k = 0; m_started = 0; m_pend = 0; m_pending = 0;
    m_out = 0; m_pulse = 0; m_ack = 0;
  endtask

  task automatic model_step(input int e, input int l, input int nd);
    if (!e) begin
      if (l) begin m_pend = 1; m_pending = nd; end
      m_pulse = 0; m_ack = 0;
    end else begin
      if (!m_started || m_n == 0 || m_k == m_n - 1) begin
        m_ack = (l || m_pend) ? 1 : 0;
        if (l) m_n = nd;
        else if (m_pend) m_n = m_pending;
        m_pend = 0; m_started = 1; m_k = 0;
      end else begin
        m_k++;
        if (l) begin m_pend = 1; m_pending = nd; end
        m_ack = 0;
      end
      m_out   = (m_n > 0 && m_k < (m_n + 1) / 2) ? 1 : 0;
      m_pulse = (m_n > 0 && m_k == 0) ? 1 : 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l, input int nd);
    exp_t x;
    reset = r; en = e; load = l; ndiv = nd[7:0];
    @(posedge clk);
    if (r) model_reset();
    else model_step(int'(e), int'(l), nd);
    x.ph = m_k; x.o = m_out; x.p = m_pulse; x.a = m_ack;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic run_until(input int k);
    for (int i = 0; i < 600 && m_k != k; i++) step(1'b0, 1'b1, 1'b0, 0);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() != 0) begin
      x = q.pop_front();
      chk("phase", int'(phase), x.ph);
      chk("div_out", int'(div_out), x.o);
      chk("div_pulse", int'(div_pulse), x.p);
      chk("load_ack", int'(load_ack), x.a);
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    run(12);
    run_until(1);
    step(1'b0, 1'b1, 1'b1, 5);
    run(14);
    step(1'b0, 1'b1, 1'b1, 4);
    run(10);
    run_until(0);
    step(1'b0, 1'b1, 1'b1, 7);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 3);
    run(10);
    step(1'b0, 1'b1, 1'b1, 6);
    run(8);
    run_until(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
    run(8);
    step(1'b0, 1'b1, 1'b1, 0);
    run(4);
    step(1'b0, 1'b1, 1'b1, 1);
    run(4);
    step(1'b0, 1'b1, 1'b1, 255);
    run_until(0);
    run(260);
    run_until(100);
    chk("phase_before_reset", int'(phase), 100);
    reset = 1'b1;
    #1;
    chk("async_phase", int'(phase), 0);
    chk("async_div_out", int'(div_out), 0);
    chk("async_div_pulse", int'(div_pulse), 0);
    chk("async_load_ack", int'(load_ack), 0);
    model_reset();
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 0);
    run(9);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 9)));
    end
    run(2);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
